// File: rtl/reconhecimento_pkg.sv
// Shared types and sizes for the digit recognizer scoring path.
package reconhecimento_pkg;
  localparam int N        = 11;
  localparam int PIXEL_W  = 8;
  localparam int LINHA_W  = 12;
  localparam int SOMA_W   = 15;
  localparam int DIGITO_W = 4;
  localparam int IDX_W    = 4;

  typedef logic [PIXEL_W-1:0] pixel_t;

  typedef enum logic {
    IDLE,
    SOMA
  } estado_t;
endpackage

// File: rtl/soma_linha.sv
// Combinational sum of one snapshot row (11 pixels of 8 bits into 12 bits).
module soma_linha
  import reconhecimento_pkg::*;
(
  input  pixel_t             linha_i [N-1:0],
  output logic [LINHA_W-1:0] soma_o
);

  always_comb begin
    soma_o = '0;
    for (int c = 0; c < N; c++) begin
      soma_o = soma_o + LINHA_W'(linha_i[c]);
    end
  end

endmodule

// File: rtl/acumulador_diferenca.sv
// Row-serial template-distance scorer; ACUMULADOR_MIN_EN adds a best-match tracker.
// state | meaning
// IDLE  | waiting for start; snapshot taken on accept
// SOMA  | adding one snapshot row per clock, rows 0..10
module acumulador_diferenca
  import reconhecimento_pkg::*;
#(
  parameter int N       = reconhecimento_pkg::N,
  parameter int PIXEL_W = reconhecimento_pkg::PIXEL_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [DIGITO_W-1:0] digito,
  input  pixel_t              diff_pixel [N-1:0][N-1:0],
`ifdef ACUMULADOR_MIN_EN
  input  logic                limpar,
  output logic                melhor_valido,
  output logic [SOMA_W-1:0]   melhor_soma,
  output logic [DIGITO_W-1:0] melhor_digito,
`endif
  output logic                busy,
  output logic                done,
  output logic [SOMA_W-1:0]   soma,
  output logic [DIGITO_W-1:0] soma_digito
);

  localparam logic [IDX_W-1:0] LINHA_ULT = IDX_W'(N - 1);

  estado_t               estado_q, estado_d;
  logic                  aceitar, concluir;
  pixel_t                snap_q [N-1:0][N-1:0];
  pixel_t                linha_sel [N-1:0];
  logic [IDX_W-1:0]      linha_q;
  logic [SOMA_W-1:0]     acc_q, soma_q, soma_nova;
  logic [DIGITO_W-1:0]   dig_q, soma_dig_q;
  logic                  done_q;
  logic [LINHA_W-1:0]    soma_linha_w;
`ifdef ACUMULADOR_MIN_EN
  logic                  mv_q;
  logic [SOMA_W-1:0]     ms_q;
  logic [DIGITO_W-1:0]   md_q;
`endif

  always_comb begin
    for (int c = 0; c < N; c++) begin
      linha_sel[c] = snap_q[linha_q][c];
    end
  end

  soma_linha u_soma_linha (
    .linha_i (linha_sel),
    .soma_o  (soma_linha_w)
  );

  assign soma_nova = acc_q + SOMA_W'(soma_linha_w);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) estado_q <= IDLE;
    else        estado_q <= estado_d;
  end

  always_comb begin
    estado_d = estado_q;
    aceitar  = 1'b0;
    concluir = 1'b0;
    case (estado_q)
      IDLE: if (start) begin
        estado_d = SOMA;
        aceitar  = 1'b1;
      end
      SOMA: if (linha_q == LINHA_ULT) begin
        estado_d = IDLE;
        concluir = 1'b1;
      end
      default: estado_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < N; r++)
        for (int c = 0; c < N; c++)
          snap_q[r][c] <= '0;
      linha_q    <= '0;
      acc_q      <= '0;
      dig_q      <= '0;
      soma_q     <= '0;
      soma_dig_q <= '0;
      done_q     <= 1'b0;
`ifdef ACUMULADOR_MIN_EN
      mv_q <= 1'b0;
      ms_q <= '0;
      md_q <= '0;
`endif
    end else begin
      done_q <= concluir;
      if (aceitar) begin
        snap_q  <= diff_pixel;
        dig_q   <= digito;
        linha_q <= '0;
        acc_q   <= '0;
      end else if (estado_q == SOMA) begin
        acc_q   <= soma_nova;
        linha_q <= linha_q + 1'b1;
      end
      if (concluir) begin
        soma_q     <= soma_nova;
        soma_dig_q <= dig_q;
      end
`ifdef ACUMULADOR_MIN_EN
      // Clearing takes priority over a result completing on the same edge.
      if (limpar) begin
        mv_q <= 1'b0;
        ms_q <= '0;
        md_q <= '0;
      end else if (concluir && (!mv_q || soma_nova < ms_q)) begin
        mv_q <= 1'b1;
        ms_q <= soma_nova;
        md_q <= dig_q;
      end
`endif
    end
  end

  assign busy        = (estado_q == SOMA);
  assign done        = done_q;
  assign soma        = soma_q;
  assign soma_digito = soma_dig_q;
`ifdef ACUMULADOR_MIN_EN
  assign melhor_valido = mv_q;
  assign melhor_soma   = ms_q;
  assign melhor_digito = md_q;
`endif

endmodule

// File: tb/tb_acumulador_diferenca.sv
// Self-checking bench for acumulador_diferenca; tracker checks need ACUMULADOR_MIN_EN.
module tb_acumulador_diferenca;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [3:0] digito;
  logic [7:0] diff_pixel [10:0][10:0];
  logic       busy, done;
  logic [14:0] soma;
  logic [3:0]  soma_digito;
`ifdef ACUMULADOR_MIN_EN
  logic        limpar;
  logic        melhor_valido;
  logic [14:0] melhor_soma;
  logic [3:0]  melhor_digito;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  acumulador_diferenca dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .digito        (digito),
    .diff_pixel    (diff_pixel),
`ifdef ACUMULADOR_MIN_EN
    .limpar        (limpar),
    .melhor_valido (melhor_valido),
    .melhor_soma   (melhor_soma),
    .melhor_digito (melhor_digito),
`endif
    .busy          (busy),
    .done          (done),
    .soma          (soma),
    .soma_digito   (soma_digito)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    int modo;     // 1: every pixel = val, 2: pixel = row index, 3: pixel = col * val
    int val;
    int dig;
    int esperado;
  } vetor_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nome, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nome, got, exp);
    end
  endtask

  function automatic int modelo();
    int s = 0;
    for (int r = 0; r < 11; r++)
      for (int c = 0; c < 11; c++)
        s += int'(diff_pixel[r][c]);
    return s;
  endfunction

  task automatic preenche(input int modo, input int val);
    for (int r = 0; r < 11; r++)
      for (int c = 0; c < 11; c++)
        case (modo)
          2:       diff_pixel[r][c] = 8'(r);
          3:       diff_pixel[r][c] = 8'(c * val);
          default: diff_pixel[r][c] = 8'(val);
        endcase
  endtask

  task automatic preenche_aleatorio();
    for (int r = 0; r < 11; r++)
      for (int c = 0; c < 11; c++)
        diff_pixel[r][c] = 8'($urandom_range(0, 255));
  endtask

  task automatic preenche_total(input int total);
    int resto = total;
    int v;
    for (int r = 0; r < 11; r++)
      for (int c = 0; c < 11; c++) begin
        v = (resto > 255) ? 255 : resto;
        diff_pixel[r][c] = 8'(v);
        resto -= v;
      end
  endtask

  // One complete run: inputs are scrambled right after the accept edge.
  task automatic executar(input int dig, input bit pedido_extra, input int esperado);
    int  n;
    bit  visto;
    digito = 4'(dig);
    start  = 1'b1;
    tick();
    start = 1'b0;
    check("busy_after_accept", busy, 1);
    preenche_aleatorio();
    digito = ~digito;
    n = 0;
    visto = 1'b0;
    while (n < 20 && !visto) begin
      start = pedido_extra && (n == 5);
      tick();
      n++;
      visto = done;
    end
    start = 1'b0;
    check("latency", visto ? n : -1, 11);
    check("soma", soma, esperado);
    check("soma_digito", soma_digito, dig);
    check("busy_at_done", busy, 0);
    tick();
    check("done_one_cycle", done, 0);
    check("busy_after_done", busy, 0);
  endtask

  initial begin
    vetor_t tab [6];
    int exp_a, exp_b, nd;
    int pos [$];

    tab[0] = '{1, 0, 3, 0};
    tab[1] = '{1, 255, 5, 30855};
    tab[2] = '{2, 0, 4, 605};
    tab[3] = '{3, 2, 8, 1210};
    tab[4] = '{1, 1, 0, 121};
    tab[5] = '{1, 200, 15, 24200};

    rst_n  = 1'b0;
    start  = 1'b0;
    digito = '0;
    preenche(1, 0);
`ifdef ACUMULADOR_MIN_EN
    limpar = 1'b0;
`endif
    tick();
    tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_soma", soma, 0);
    check("rst_soma_digito", soma_digito, 0);
`ifdef ACUMULADOR_MIN_EN
    check("rst_melhor_valido", melhor_valido, 0);
    check("rst_melhor_soma", melhor_soma, 0);
    check("rst_melhor_digito", melhor_digito, 0);
`endif
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 6; i++) begin
      preenche(tab[i].modo, tab[i].val);
      executar(tab[i].dig, i == 2, tab[i].esperado);
    end

    for (int i = 0; i < 8; i++) begin
      preenche_aleatorio();
      executar(int'($urandom_range(0, 15)), i[0], modelo());
    end

    // start held high: second run accepted in the done cycle, third blocked.
    preenche_aleatorio();
    exp_a  = modelo();
    digito = 4'd2;
    start  = 1'b1;
    tick();
    preenche_aleatorio();
    exp_b  = modelo();
    digito = 4'd9;
    nd = 0;
    for (int t = 1; t <= 30; t++) begin
      if (t == 24) start = 1'b0;
      tick();
      if (done) begin
        nd++;
        pos.push_back(t);
        check("held_soma", soma, (nd == 1) ? exp_a : exp_b);
        check("held_digito", soma_digito, (nd == 1) ? 2 : 9);
      end
    end
    start = 1'b0;
    check("held_done_count", nd, 2);
    check("held_done_pos1", (pos.size() > 0) ? pos[0] : -1, 11);
    check("held_done_pos2", (pos.size() > 1) ? pos[1] : -1, 23);
    check("held_busy_end", busy, 0);

`ifdef ACUMULADOR_MIN_EN
    limpar = 1'b1;
    tick();
    limpar = 1'b0;
    check("clear_valid", melhor_valido, 0);
    preenche_total(500);
    executar(3, 1'b0, 500);
    check("trk1_valid", melhor_valido, 1);
    check("trk1_soma", melhor_soma, 500);
    check("trk1_dig", melhor_digito, 3);
    preenche_total(400);
    executar(7, 1'b0, 400);
    check("trk2_soma", melhor_soma, 400);
    check("trk2_dig", melhor_digito, 7);
    preenche_total(400);
    executar(1, 1'b0, 400);
    check("trk_tie_soma", melhor_soma, 400);
    check("trk_tie_dig", melhor_digito, 7);
    preenche_total(900);
    executar(4, 1'b0, 900);
    check("trk_worse_dig", melhor_digito, 7);
    limpar = 1'b1;
    tick();
    limpar = 1'b0;
    check("limpar_valid", melhor_valido, 0);
    check("limpar_soma", melhor_soma, 0);
    check("limpar_dig", melhor_digito, 0);
    // limpar on the completion edge
    preenche_total(321);
    digito = 4'd6;
    start  = 1'b1;
    tick();
    start = 1'b0;
    for (int t = 1; t <= 10; t++) tick();
    limpar = 1'b1;
    tick();
    limpar = 1'b0;
    check("lcoinc_done", done, 1);
    check("lcoinc_soma", soma, 321);
    check("lcoinc_valid", melhor_valido, 0);
    check("lcoinc_msoma", melhor_soma, 0);
    tick();
`endif

    // Reset during row 5 aborts the run.
    preenche(1, 9);
    digito = 4'd5;
    start  = 1'b1;
    tick();
    start = 1'b0;
    for (int t = 1; t <= 5; t++) tick();
    check("pre_abort_busy", busy, 1);
    rst_n = 1'b0;
    #2;
    check("abort_busy", busy, 0);
    check("abort_soma", soma, 0);
    check("abort_done", done, 0);
    check("abort_digito", soma_digito, 0);
`ifdef ACUMULADOR_MIN_EN
    check("abort_melhor_valido", melhor_valido, 0);
    check("abort_melhor_soma", melhor_soma, 0);
`endif
    rst_n = 1'b1;
    nd = 0;
    for (int t = 0; t < 15; t++) begin
      tick();
      if (done) nd++;
    end
    check("abort_no_done", nd, 0);
    check("abort_soma_after", soma, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
